// File: rtl/alu_ctrl_pipe_pkg.sv
// Shared ALU control encodings and decode helpers for the registered ALU control stage.
package alu_ctrl_pipe_pkg;

  // Base codes occupy 5'b00xxx / 5'b01xxx; M-extension ops are {2'b10, funct3}.
  localparam logic [4:0] ALU_ADD    = 5'b00000;
  localparam logic [4:0] ALU_SUB    = 5'b00001;
  localparam logic [4:0] ALU_SLL    = 5'b00010;
  localparam logic [4:0] ALU_SLT    = 5'b00011;
  localparam logic [4:0] ALU_SLTU   = 5'b00100;
  localparam logic [4:0] ALU_XOR    = 5'b00101;
  localparam logic [4:0] ALU_SRL    = 5'b00110;
  localparam logic [4:0] ALU_SRA    = 5'b00111;
  localparam logic [4:0] ALU_OR     = 5'b01000;
  localparam logic [4:0] ALU_AND    = 5'b01001;
  localparam logic [4:0] ALU_MUL    = 5'b10000;
  localparam logic [4:0] ALU_MULH   = 5'b10001;
  localparam logic [4:0] ALU_MULHSU = 5'b10010;
  localparam logic [4:0] ALU_MULHU  = 5'b10011;
  localparam logic [4:0] ALU_DIV    = 5'b10100;
  localparam logic [4:0] ALU_DIVU   = 5'b10101;
  localparam logic [4:0] ALU_REM    = 5'b10110;
  localparam logic [4:0] ALU_REMU   = 5'b10111;

  localparam logic [1:0] ALUOP_LS = 2'b00;
  localparam logic [1:0] ALUOP_BR = 2'b01;
  localparam logic [1:0] ALUOP_R  = 2'b10;
  localparam logic [1:0] ALUOP_I  = 2'b11;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  typedef struct packed {
    logic [4:0] code;
    logic       word;
    logic       mext;
    logic       illegal;
  } dec_t;

  function automatic logic [4:0] base_code(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic word_base_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b101);
  endfunction

  // Word M ops drop MULH/MULHSU/MULHU.
  function automatic logic word_mext_ok(input logic [2:0] f3);
    return (f3 == 3'b000) || f3[2];
  endfunction

endpackage

// File: rtl/alu_ctrl_pipe_decode.sv
// Pure combinational ALUOp/funct7/funct3 decode into a 5-bit ALU control word.
module alu_ctrl_decode
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int XLEN = 32,
  parameter bit MEXT = 1'b1
) (
  input  logic [1:0] ALUOp,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic       is_word,
  output logic [4:0] code,
  output logic       word,
  output logic       mext,
  output logic       illegal
);

  localparam bit RV64 = (XLEN == 64);

  logic       wop;
  logic [6:0] shkey;

  assign wop   = RV64 && is_word;
  // RV64 non-word immediate shifts carry shamt[5] in funct7[0].
  assign shkey = (RV64 && !is_word) ? {funct7[6:1], 1'b0} : funct7;

  always_comb begin
    code    = ALU_ADD;
    word    = 1'b0;
    mext    = 1'b0;
    illegal = 1'b0;
    case (ALUOp)
      ALUOP_LS: code = ALU_ADD;
      ALUOP_BR: code = ALU_SUB;
      ALUOP_R: begin
        if (funct7 == F7_ZERO) begin
          code    = base_code(funct3);
          illegal = wop && !word_base_ok(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          code = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          code = ALU_SRA;
        end else if (MEXT && funct7 == F7_MEXT) begin
          code    = {2'b10, funct3};
          mext    = 1'b1;
          illegal = wop && !word_mext_ok(funct3);
        end else begin
          illegal = 1'b1;
        end
        word = wop;
      end
      default: begin
        if (wop && !word_base_ok(funct3)) begin
          illegal = 1'b1;
        end else if (funct3 == 3'b001) begin
          code    = ALU_SLL;
          illegal = (shkey != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          if (shkey == F7_ZERO)     code = ALU_SRL;
          else if (shkey == F7_ALT) code = ALU_SRA;
          else                      illegal = 1'b1;
        end else begin
          code = base_code(funct3);
        end
        word = wop;
      end
    endcase
    if (illegal) begin
      code = ALU_ADD;
      mext = 1'b0;
      word = 1'b0;
    end
  end

endmodule

// File: rtl/alu_ctrl_pipe.sv
// Registered ALU control stage: valid/ready in and out, one hold register, MUL/DIV issue stall.
module alu_ctrl_pipe
  import alu_ctrl_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter bit MEXT    = 1'b1,
  parameter int MUL_LAT = 2,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] ALUOp,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  input  logic       is_word,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] ALUCtrl,
  output logic       out_word,
  output logic       out_mext,
  output logic       out_illegal,
  output logic       mc_busy
);

  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT);
  localparam logic [3:0] DIV_CNT = 4'(DIV_LAT);

  dec_t       dec;
  dec_t       out_q, out_d;
  logic       hold_q, hold_d;
  logic [3:0] cnt_q, cnt_d;
  logic       in_hs, out_hs;

  alu_ctrl_decode #(.XLEN(XLEN), .MEXT(MEXT)) u_dec (
    .ALUOp   (ALUOp),
    .funct7  (funct7),
    .funct3  (funct3),
    .is_word (is_word),
    .code    (dec.code),
    .word    (dec.word),
    .mext    (dec.mext),
    .illegal (dec.illegal)
  );

  assign mc_busy     = (cnt_q != 4'd0);
  assign out_valid   = hold_q && !mc_busy;
  assign in_ready    = !hold_q || (out_ready && !mc_busy);
  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign ALUCtrl     = out_q.code;
  assign out_word    = out_q.word;
  assign out_mext    = out_q.mext;
  assign out_illegal = out_q.illegal;

  always_comb begin
    hold_d = hold_q;
    out_d  = out_q;
    cnt_d  = cnt_q;
    if (out_hs) hold_d = 1'b0;
    if (in_hs) begin
      hold_d = 1'b1;
      out_d  = dec;
    end
    // Latency class follows funct3[2], which lands in code[2] for M ops.
    if (out_hs && out_q.mext)  cnt_d = out_q.code[2] ? DIV_CNT : MUL_CNT;
    else if (cnt_q != 4'd0)    cnt_d = cnt_q - 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q <= 1'b0;
      out_q  <= '{code: ALU_ADD, word: 1'b0, mext: 1'b0, illegal: 1'b0};
      cnt_q  <= 4'd0;
    end else begin
      hold_q <= hold_d;
      out_q  <= out_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: doc/alu_ctrl_pipe.md
# alu_ctrl_pipe

Registered, parametrised successor to the combinational ALU control decode in the execute stage. Accepts ALUOp/funct7/funct3 from the ID/EX boundary over a valid/ready handshake, decodes RV32I/RV64I base ops plus optional M-extension ops into a 5-bit ALU control word, and flags illegal encodings. It also holds the downstream issue slot for a fixed number of cycles after any multi-cycle MUL/DIV op.

## Interface
- XLEN, 32: datapath width, 32 or 64; 64 enables word (`*W`) ops.
- MEXT, 1: 1 decodes M-extension ops; 0 treats them as illegal.
- MUL_LAT, 2: stall cycles after a MUL-class issue, 0..15.
- DIV_LAT, 8: stall cycles after a DIV/REM-class issue, 0..15.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode request valid.
- in_ready  out  1  request accepted when in_valid && in_ready.
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type.
- funct7  in  7  instruction funct7; for I-type, imm[11:5].
- funct3  in  3  instruction funct3.
- is_word  in  1  OP-32/OP-IMM-32; ignored when XLEN=32.
- out_valid  out  1  control word valid.
- out_ready  in  1  downstream accepts.
- ALUCtrl  out  5  decoded control.
- out_word  out  1  result is sign-extended from bit 31.
- out_mext  out  1  op is an M-extension op.
- out_illegal  out  1  encoding illegal.
- mc_busy  out  1  multi-cycle stall counter non-zero.

## Operation
- Base codes: existing `ADD..`AND values, zero-extended to 5 bits. M codes: {2'b10, funct3}.
- ALUOp 00 -> ADD. ALUOp 01 -> SUB. In both cases funct fields are ignored and illegal=0.
- ALUOp 10, funct7=0000000: funct3 maps to ADD/SLL/SLT/SLTU/XOR/SRL/OR/AND.
- ALUOp 10, funct7=0100000: legal only with funct3 000 (SUB) or 101 (SRA).
- ALUOp 10, funct7=0000001 with MEXT=1: M op, out_mext=1.
- ALUOp 11: funct3 000/010/011/100/110/111 ignore funct7.
  - Shifts (001 and 101) compare funct7[6:1] when XLEN=64 && !is_word; otherwise they compare the full funct7.
  - The legal shift set is SLL (funct3 001, zeros), SRL (funct3 101, zeros) and SRA (funct3 101, 010000x).
- is_word && XLEN=64:
  - Legal base funct3: {000, 001, 101}. SUB applies to R-type only.
  - Legal M funct3: {000, 100, 101, 110, 111}.
  - out_word=1.
- Any other combination: ALUCtrl=ADD, out_illegal=1, out_mext=0, out_word=0.
- MUL class is funct3[2]=0. DIV/REM class is funct3[2]=1.

## Timing
- Single output register (hold_q). Decode is registered, so latency is 1 cycle from input handshake to out_valid.
- out_valid = hold_q && !mc_busy.
- in_ready = !hold_q || (out_ready && !mc_busy).
- Stall counter (4 bits):
  - An output handshake of an out_mext op loads MUL_LAT or DIV_LAT.
  - Otherwise the counter decrements when non-zero.
  - mc_busy = (cnt != 0).
  - A LAT value of 0 produces no stall.
- M op handshaked at edge k with latency N: mc_busy is high for the N cycles after edge k, and out_valid is next possible after edge k+N.
- Simultaneous output and input handshake: the new op loads at the same edge the old one leaves. It is then masked while mc_busy is high.
- A held op must keep all output fields stable while out_valid && !out_ready, and also while masked by mc_busy.
- Illegal ops pass through the handshake like any other op and never load the counter.
- Reset (asynchronous, at any time, including mid-stall):
  - hold_q=0, cnt=0, out_valid=0, mc_busy=0.
  - ALUCtrl=ADD, out_word=0, out_mext=0, out_illegal=0.
  - in_ready=1 while rst_n is high after reset.

## Structure
- Shared constants in defines.vh: existing base ALU codes widened to 5 bits, new `MUL/`MULH/`MULHSU/`MULHU/`DIV/`DIVU/`REM/`REMU, ALUOp encodings.
- Natural sub-module: alu_ctrl_decode, pure combinational decode. Inputs: ALUOp, funct7, funct3, is_word. Outputs: code, word, mext, illegal.
- Top level holds the output register, the handshake logic and the stall counter.

## Test plan
- Full sweep: ALUOp=10, all funct3 with funct7 0000000/0100000, out_ready=1.
  - Each result appears 1 cycle after accept.
  - funct3 000 gives ADD/SUB, funct3 101 gives SRL/SRA.
  - Other 0100000 combinations give illegal=1 with ALUCtrl=ADD.
- MUL then DIV back-to-back, MUL_LAT=2, DIV_LAT=8, out_ready=1.
  - MUL (code 10000) is presented, then out_valid is low for 2 cycles.
  - DIV (10100) is presented, then out_valid is low for 8 cycles.
- Backpressure: out_ready=0 for 5 cycles with SLT held.
  - in_ready=0 and ALUCtrl stays at `SLT.
  - Release gives exactly one output handshake.
- Parameter variants:
  - MEXT=0 with funct7=0000001: illegal=1, no stall.
  - XLEN=64, is_word=1, ALUOp=11, funct3=101, funct7=0100000: SRA with out_word=1.
  - XLEN=64, is_word=1, MULH: illegal.
- XLEN=64 I-type SRAI with funct7=0100001 (shamt[5]=1): SRA, illegal=0.
- Reset asserted mid-DIV stall (cnt=5): all outputs go to reset values immediately. After release, an ADD request is accepted and output with no residual stall.
